// File: rtl/clock_font_pkg.sv
// Shared types, constants and glyph helpers for the clock font fetch path.
package clock_font_pkg;

  localparam int unsigned NUM_SLOTS   = 8;
  localparam int unsigned GLYPH_COLON = 10;
  localparam int unsigned GLYPH_BYTES = 256;
  localparam int unsigned STEP_W      = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  // Per-line snapshot taken when a fill starts or restarts
  typedef struct packed {
    logic [23:0] digits;
    logic        h_blank;
    logic        l_blank;
    logic [5:0]  row;
    logic        active;
  } line_snap_t;

  // Tag that travels with each step until its ROM data returns
  typedef struct packed {
    logic       valid;
    logic [2:0] slot;
    logic [1:0] bidx;
    logic       nul;
  } cap_tag_t;

  // Slot to glyph index: digit field or the colon glyph
  function automatic logic [3:0] slot_glyph(input logic [2:0] slot, input logic [23:0] digits);
    logic [3:0] g;
    case (slot)
      3'd0:    g = digits[23:20];
      3'd1:    g = digits[19:16];
      3'd3:    g = digits[15:12];
      3'd4:    g = digits[11:8];
      3'd6:    g = digits[7:4];
      3'd7:    g = digits[3:0];
      default: g = 4'(GLYPH_COLON);
    endcase
    return g;
  endfunction

  // Tens-of-hours may only be 0..2; other digits 0..9; colon always valid
  function automatic logic glyph_valid(input logic [2:0] slot, input logic [3:0] glyph);
    logic v;
    case (slot)
      3'd2, 3'd5: v = 1'b1;
      3'd0:       v = (glyph <= 4'd2);
      default:    v = (glyph <= 4'd9);
    endcase
    return v;
  endfunction

  // Blink blanking: hours on slots 0-1, minutes on slots 3-4
  function automatic logic slot_blanked(input logic [2:0] slot, input logic h_blank, input logic l_blank);
    return (h_blank && (slot == 3'd0 || slot == 3'd1)) ||
           (l_blank && (slot == 3'd3 || slot == 3'd4));
  endfunction

  function automatic int unsigned glyph_addr(input logic [3:0] glyph, input logic [5:0] row,
                                             input logic [1:0] bidx, input int unsigned bytes_per_row);
    return 32'(glyph) * GLYPH_BYTES + 32'(row) * bytes_per_row + 32'(bidx);
  endfunction

endpackage

// File: rtl/glyph_fetch_sched_line_buf.sv
// Ping-pong line buffer: one bank is filled while the other feeds pixels.
module glyph_line_buf
  import clock_font_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       swap,
  input  logic       wr_en,
  input  logic [2:0] wr_slot,
  input  logic [1:0] wr_bidx,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_slot,
  input  logic [4:0] rd_col,
  output logic       rd_bit
);

  // Byte 0 of a row lives in the top byte so column 0 is the word MSB
  logic [NUM_SLOTS-1:0][3:0][7:0] bank0;
  logic [NUM_SLOTS-1:0][3:0][7:0] bank1;
  logic                           sel;
  logic [3:0][7:0]                word;

  // Display bank select; the other bank is the fill bank
  always_ff @(posedge clk) begin
    if (rst) sel <= 1'b0;
    else if (swap) sel <= ~sel;
  end

  // Fill-bank write port
  always_ff @(posedge clk) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (wr_en) begin
      if (sel) bank0[wr_slot][~wr_bidx] <= wr_data;
      else     bank1[wr_slot][~wr_bidx] <= wr_data;
    end
  end

  assign word   = sel ? bank1[rd_slot] : bank0[rd_slot];
  assign rd_bit = word[~rd_col[4:3]][~rd_col[2:0]];

endmodule

// File: rtl/glyph_fetch_sched.sv
// Per-line font ROM fetch scheduler for the eight clock character slots.
module glyph_fetch_sched
  import clock_font_pkg::*;
#(
  parameter int unsigned GLYPH_ROWS    = 64,
  parameter int unsigned BYTES_PER_ROW = 4,
  parameter int unsigned ROM_AW        = 12,
  parameter int unsigned ROM_LAT       = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_req,
  input  logic [5:0]        line_row,
  input  logic              line_active,
  input  logic [23:0]       digits,
  input  logic              h_blank_en,
  input  logic              l_blank_en,
  output logic              rom_rd,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  input  logic [2:0]        pix_slot,
  input  logic [4:0]        pix_col,
  output logic              pix_bit,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  localparam int unsigned LAST_STEP = NUM_SLOTS * 4 - 1;
  localparam int unsigned DRAIN_W   = 2;

  fetch_state_t       state, state_n;
  logic [STEP_W-1:0]  step, step_n;
  logic [DRAIN_W-1:0] drain_cnt, drain_n;
  line_snap_t         snap, snap_n;
  cap_tag_t           cur, cur_n;
  cap_tag_t           pipe [ROM_LAT];
  logic               rom_rd_n, done_n, null_n;
  logic [ROM_AW-1:0]  rom_addr_n;
  logic [3:0]         glyph_n;
  logic               swap, restart, wr_en;

  assign swap    = line_req && (state == S_IDLE);
  assign restart = line_req && (state != S_IDLE);
  assign overrun = restart;

  // Next state, next step and the registered ROM request for that step
  always_comb begin
    state_n    = state;
    step_n     = step;
    drain_n    = drain_cnt;
    snap_n     = snap;
    done_n     = 1'b0;
    rom_rd_n   = 1'b0;
    rom_addr_n = rom_addr;
    cur_n      = '0;
    glyph_n    = '0;
    null_n     = 1'b0;
    if (line_req) begin
      state_n = S_FETCH;
      step_n  = '0;
      snap_n  = '{digits: digits, h_blank: h_blank_en, l_blank: l_blank_en,
                  row: line_row & 6'(GLYPH_ROWS - 1), active: line_active};
    end else begin
      case (state)
        S_FETCH: begin
          if (step == STEP_W'(LAST_STEP)) begin
            state_n = S_DRAIN;
            drain_n = '0;
          end else begin
            step_n = step + STEP_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_W'(ROM_LAT - 1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            drain_n = drain_cnt + DRAIN_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (state_n == S_FETCH) begin
      glyph_n  = slot_glyph(step_n[4:2], snap_n.digits);
      null_n   = !snap_n.active || slot_blanked(step_n[4:2], snap_n.h_blank, snap_n.l_blank) ||
                 !glyph_valid(step_n[4:2], glyph_n);
      rom_rd_n = !null_n;
      if (!null_n)
        rom_addr_n = ROM_AW'(glyph_addr(glyph_n, snap_n.row, step_n[1:0], BYTES_PER_ROW));
      cur_n = '{valid: 1'b1, slot: step_n[4:2], bidx: step_n[1:0], nul: null_n};
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      drain_cnt <= '0;
      snap      <= '0;
      cur       <= '0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      line_done <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      drain_cnt <= drain_n;
      snap      <= snap_n;
      cur       <= cur_n;
      rom_rd    <= rom_rd_n;
      rom_addr  <= rom_addr_n;
      busy      <= (state_n != S_IDLE);
      line_done <= done_n;
    end
  end

  // Capture pipeline aligning step tags with returning ROM data; flushed on restart
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign wr_en = pipe[ROM_LAT-1].valid && !restart;

  glyph_line_buf u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .swap    (swap),
    .wr_en   (wr_en),
    .wr_slot (pipe[ROM_LAT-1].slot),
    .wr_bidx (pipe[ROM_LAT-1].bidx),
    .wr_data (pipe[ROM_LAT-1].nul ? 8'h00 : rom_q),
    .rd_slot (pix_slot),
    .rd_col  (pix_col),
    .rd_bit  (pix_bit)
  );

endmodule

// File: doc/glyph_fetch_sched.md
# glyph_fetch_sched

Schedules reads of the single shared font ROM for the eight character slots of the VGA digital clock (HH:MM:SS). It replaces the per-digit parallel glyph memories with one ROM. During each horizontal blanking interval it fetches one glyph row for every slot into a ping-pong line buffer. The VGA pixel path then reads single pixel bits from the display bank with no ROM access.

## Interface
Parameters:
- GLYPH_ROWS, default 64: rows per glyph.
- BYTES_PER_ROW, default 4: bytes per glyph row, giving 32-pixel-wide glyphs.
- ROM_AW, default 12: ROM address width; 11 glyphs × 256 B = 2816 B.
- ROM_LAT, default 1: ROM read latency in cycles; legal values are 1 and 2.

Ports:
- clk, in, 1: pixel clock (25 MHz).
- rst, in, 1: synchronous, active-high reset.
- line_req, in, 1: one-cycle pulse at the start of horizontal blanking.
- line_row, in, 6: glyph row to fetch for the next line.
- line_active, in, 1: next line lies inside the text band; 0 means fill with zeros.
- digits, in, 24: {hour_shi, hour_ge, min_shi, min_ge, sec_shi, sec_ge}, BCD.
- h_blank_en, in, 1: blank slots 0–1 (hour adjust blink).
- l_blank_en, in, 1: blank slots 3–4 (minute adjust blink).
- rom_rd, out, 1: ROM read strobe.
- rom_addr, out, ROM_AW: ROM read address.
- rom_q, in, 8: ROM read data, valid ROM_LAT cycles after rom_rd.
- pix_slot, in, 3: character slot being displayed.
- pix_col, in, 5: column within that slot.
- pix_bit, out, 1: combinational pixel from the display bank.
- busy, out, 1: fill in progress.
- line_done, out, 1: one-cycle pulse when the fill completes.
- overrun, out, 1: one-cycle pulse when line_req arrives while busy.

## Operation
- Slot map: 0 = hour_shi, 1 = hour_ge, 2 = colon, 3 = min_shi, 4 = min_ge, 5 = colon, 6 = sec_shi, 7 = sec_ge. The colon is glyph index 10.
- ROM address: glyph × 256 + line_row × BYTES_PER_ROW + byte.
- On line_req while idle:
  - swap the display and fill banks;
  - snapshot digits, h_blank_en, l_blank_en, line_row and line_active;
  - enter FETCH.
- FSM states and transitions:
  - IDLE → FETCH on line_req.
  - FETCH steps one byte per cycle, 32 steps in order: slot 0..7, then byte 0..3 within each slot. FETCH → DRAIN after the last step.
  - DRAIN waits ROM_LAT cycles for the in-flight data, then pulses line_done and returns to IDLE.
- A step is a null step when any of these hold:
  - the slot is blanked;
  - the digit is invalid (hour_shi > 2, or any other digit > 9);
  - line_active = 0.
- A null step asserts no rom_rd and writes 0x00 to the buffer; it still consumes its cycle, so fill timing is fixed.
- A capture pipeline of depth ROM_LAT carries {slot, byte, null} alongside each step and writes rom_q (or 0x00 for null steps) into fill-bank byte [slot][byte].
- pix_bit = display_bank[pix_slot] byte (pix_col >> 3), bit 7 − (pix_col & 7). Column 0 is the MSB of byte 0.
- Changes on digits during a fill have no effect, because the fill uses the snapshot.
- line_req while busy:
  - pulse overrun;
  - do not swap banks;
  - flush the capture pipeline (in-flight returns are discarded);
  - take a new snapshot and restart FETCH from slot 0, byte 0.

## Timing
- Reset values:
  - rom_rd = 0, rom_addr = 0;
  - busy = 0, line_done = 0, overrun = 0;
  - both banks all zero, display bank = 0, FSM in IDLE.
- line_req in cycle T:
  - the bank swap is visible on pix_bit at T+1;
  - the first rom_rd is issued at T+1;
  - the last step occurs at T+32;
  - line_done pulses at T+33+ROM_LAT;
  - busy is high from T+1 through T+32+ROM_LAT inclusive.
- A fill-bank byte is written ROM_LAT+1 cycles after its step (ROM_LAT cycles of latency plus one register stage).
- Total occupancy is 33+ROM_LAT cycles, which is well under the 160-cycle blanking interval.
- rst asserted mid-fill returns all state to reset values on the next edge, and any in-flight ROM data is dropped.

## Structure
- Package clock_font_pkg holds:
  - constants NUM_SLOTS = 8, GLYPH_COLON = 10, GLYPH_BYTES = 256;
  - the slot-map function, slot → digit field or colon;
  - the function glyph_addr(glyph, row, byte).
- Sub-module glyph_line_buf holds the two 8 × 32-bit banks, the fill write port, the bank-select flop and the combinational pixel read port.

## Test plan
- Digits 12:34:56, line_row = 5, ROM_LAT = 1, line_req at T. Required: 32 consecutive reads, the first address at T+1 = 1×256+20 = 276. After line_done, the next line_req makes the buffer match the model ROM row 5 for glyphs 1, 2, 10, 3, 4, 10, 5, 6.
- h_blank_en = 1 with hour = 23. Required: no rom_rd during steps 0–7, and slots 0–1 read back 0 after the swap. line_active = 0 gives zero rom_rd and an all-zero bank.
- line_req at T, then a second line_req at T+10. Required: overrun pulse at T+10, no swap, restart at T+11, and line_done at T+11+32+ROM_LAT.
- digits changed at T+5 mid-fill. Required: the buffer reflects the values snapshotted at T.
- Invalid hour_shi = 3, and ROM_LAT = 2. Required: slot 0 reads back zeros, and line_done pulses at T+35.
- rst at T+15 mid-fill. Required: all outputs return to reset values, and pix_bit = 0 for all slots and columns.
